pipe_stall_ctrl: RTL and testbench
==================================

// Module: pipe_stall_ctrl
// PURPOSE
//   Stage-enable controller that sits downstream of the hazard detection unit in the 5-stage MIPS pipeline.
//   - Consumes a load-use/branch hazard request, a multi-cycle bubble count and a branch-taken flush.
//   - Drives PC write, IF/ID write/flush and the ID/EX bubble (NoOp) select.
//   - Sequences multi-cycle stalls: lw->R-type = 1 bubble, lw->branch = 2 bubbles.
//   - Keeps saturating performance counters.
// PARAMETERS
//   CNT_W      16   width of stall_cnt and flush_cnt
// PORTS
//   clk          in   1      rising-edge clock
//   rst          in   1      synchronous reset, active-high
//   hold         in   1      global freeze (memory not ready); holds every stage and all state
//   hz_req       in   1      hazard detected for the instruction currently in ID (combinational, same cycle)
//   hz_cycles    in   2      bubbles requested with hz_req; 0 means no hazard
//   br_taken     in   1      branch/jump resolved taken in ID this cycle
//   pc_write     out  1      PC register write enable
//   ifid_write   out  1      IF/ID register write enable
//   ifid_flush   out  1      load NOP into IF/ID on next edge
//   idex_bubble  out  1      select zeroed control into ID/EX (NoOp)
//   busy         out  1      1 while in STALL state (multi-cycle stall in progress)
//   stall_cnt    out  CNT_W  bubbles inserted since reset, saturating at all-ones
//   flush_cnt    out  CNT_W  IF/ID flushes since reset, saturating at all-ones
// BEHAVIOUR
//   - One clock (clk). Reset is synchronous and active-high (rst).
//   - States: RUN, STALL. A 2-bit remaining-bubble register rem is used in STALL.
//   - Outputs are Mealy: combinational from state and inputs, effective in the same cycle as the request.
//   - Priority: rst > hold > STALL > hz_req > br_taken.
//   - rst=1: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, busy=0.
//       Next edge: state=RUN, rem=0, both counters=0. A reset mid-stall aborts the stall.
//   - hold=1 (not in reset): pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=0.
//       State, rem and counters are unchanged. hz_req and br_taken are ignored.
//   - RUN, hz_req=1, hz_cycles!=0:
//       pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0; stall_cnt++.
//       If hz_cycles>=2: next state=STALL, rem=hz_cycles-1. Otherwise stay in RUN.
//       br_taken in the same cycle is ignored: the branch operands are not ready.
//   - RUN, hz_req=0 or hz_cycles==0, br_taken=1:
//       pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=0; flush_cnt++.
//   - RUN, no request: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
//   - STALL:
//       pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0, busy=1; stall_cnt++.
//       rem decrements; when rem==1, next state=RUN.
//       hz_req, hz_cycles and br_taken are ignored in STALL.
//   - Total bubbles for a request = hz_cycles (1..3). Latency from hz_req to first bubble is 0 cycles.
//   - Counters saturate at {CNT_W{1'b1}}: no wrap-around.
//   - No X propagation: every output is defined in every state.
// TESTING
//   - Reset: assert rst for 2 cycles.
//       -> During rst: ifid_flush=1, idex_bubble=1, pc_write=0.
//       -> After release: RUN, counters=0, pc_write=1.
//   - Single bubble: hz_req=1, hz_cycles=1 for 1 cycle.
//       -> That cycle: pc_write=0, idex_bubble=1. Next cycle: pc_write=1, busy=0. stall_cnt=1.
//   - Double bubble with a branch in the middle: hz_cycles=2; hold hz_req=1 and br_taken=1 across both cycles.
//       -> 2 consecutive bubbles; busy=1 in cycle 2; ifid_flush=0 in both; flush_cnt=0; stall_cnt=2.
//   - Branch flush: br_taken=1 with hz_req=0.
//       -> ifid_flush=1, pc_write=1 that cycle; flush_cnt=1.
//   - Freeze and reset mid-stall: start hz_cycles=3; assert hold in cycle 2 for 3 cycles.
//       -> Bubble sequence pauses, then completes 3 bubbles total.
//       -> Repeat, asserting rst in cycle 2 -> RUN immediately after reset.
//   - Saturation: CNT_W=4, 20 single-cycle stalls.
//       -> stall_cnt=15 and stays there.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Stage-enable controller behind the hazard unit: PC/IF-ID write, IF-ID flush, ID-EX bubble.
// Latency: Mealy outputs, so the first bubble or flush lands in the same cycle as the request.
// Backpressure: hold freezes every stage and all internal state; a multi-cycle stall ignores new requests.
module pipe_stall_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             hz_req,
    input  logic [1:0]       hz_cycles,
    input  logic             br_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [1:0]       rem_q, rem_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             stall_inc, flush_inc;

    // Next-state and stage-enable decode; priority rst > hold > STALL > hazard > branch.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;

        if (rst) begin
            // Drain the front end while reset is asserted.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (hold) begin
            // Memory not ready: nothing moves, nothing is counted.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
        end else if (state_q == STALL) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
            // rem counts bubbles still owed including this one.
            if (rem_q <= 2'd1) begin
                state_d = RUN;
                rem_d   = 2'd0;
            end else begin
                rem_d   = rem_q - 2'd1;
            end
        end else if (hz_req && (hz_cycles != 2'd0)) begin
            // Hazard wins over a same-cycle branch: its operands are not ready yet.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
            if (hz_cycles >= 2'd2) begin
                state_d = STALL;
                rem_d   = hz_cycles - 2'd1;
            end
        end else if (br_taken) begin
            ifid_flush  = 1'b1;
            flush_inc   = 1'b1;
        end
    end

    // State, remaining-bubble and saturating counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            rem_q       <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            if (stall_inc && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (flush_inc && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign busy      = (state_q == STALL) && !rst;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: two instances (16-bit and 4-bit counters) driven in parallel.
// Outputs are checked every cycle against a bubble-debt model, plus directed literal checks.
// Directed scenarios first, then randomized traffic with occasional hold and reset.
module tb_pipe_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst, hold, hz_req, br_taken;
    logic [1:0] hz_cycles;

    logic        pw16, iw16, fl16, bb16, bz16;
    logic [15:0] sc16, fc16;
    logic        pw4, iw4, fl4, bb4, bz4;
    logic [3:0]  sc4, fc4;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl u16 (
        .clk(clk), .rst(rst), .hold(hold), .hz_req(hz_req), .hz_cycles(hz_cycles),
        .br_taken(br_taken), .pc_write(pw16), .ifid_write(iw16), .ifid_flush(fl16),
        .idex_bubble(bb16), .busy(bz16), .stall_cnt(sc16), .flush_cnt(fc16)
    );

    pipe_stall_ctrl #(.CNT_W(4)) u4 (
        .clk(clk), .rst(rst), .hold(hold), .hz_req(hz_req), .hz_cycles(hz_cycles),
        .br_taken(br_taken), .pc_write(pw4), .ifid_write(iw4), .ifid_flush(fl4),
        .idex_bubble(bb4), .busy(bz4), .stall_cnt(sc4), .flush_cnt(fc4)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, got, exp);
    endtask

    // ---------------- behavioural model ----------------
    // The model tracks how many bubbles are still owed and the event totals.
    int          owed = 0;
    bit          known = 0;
    int unsigned n_stall = 0, n_flush = 0;

    function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

    always @(negedge clk) begin
        logic e_pw, e_iw, e_fl, e_bb, e_bz;
        e_pw = 1; e_iw = 1; e_fl = 0; e_bb = 0; e_bz = (owed > 0);
        if (rst) begin
            e_pw = 0; e_iw = 0; e_fl = 1; e_bb = 1; e_bz = 0;
        end else if (hold) begin
            e_pw = 0; e_iw = 0;
        end else if (owed > 0 || (hz_req && hz_cycles != 0)) begin
            e_pw = 0; e_iw = 0; e_bb = 1;
        end else if (br_taken) begin
            e_fl = 1;
        end

        chk("pc_write16", pw16, e_pw);   chk("pc_write4", pw4, e_pw);
        chk("ifid_write16", iw16, e_iw); chk("ifid_write4", iw4, e_iw);
        chk("ifid_flush16", fl16, e_fl); chk("ifid_flush4", fl4, e_fl);
        chk("idex_bubble16", bb16, e_bb); chk("idex_bubble4", bb4, e_bb);
        chk("busy16", bz16, e_bz);       chk("busy4", bz4, e_bz);
        if (known) begin
            chk("stall_cnt16", sc16, sat(n_stall, 65535));
            chk("flush_cnt16", fc16, sat(n_flush, 65535));
            chk("stall_cnt4", sc4, sat(n_stall, 15));
            chk("flush_cnt4", fc4, sat(n_flush, 15));
        end

        // advance the model to what the next edge should produce
        if (rst) begin
            owed = 0; n_stall = 0; n_flush = 0; known = 1;
        end else if (!hold) begin
            if (owed > 0) begin
                owed = owed - 1; n_stall = n_stall + 1;
            end else if (hz_req && hz_cycles != 0) begin
                owed = int'(hz_cycles) - 1; n_stall = n_stall + 1;
            end else if (br_taken) begin
                n_flush = n_flush + 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic r, input logic h, input logic hz, input logic [1:0] hc, input logic br);
        @(posedge clk);
        #1;
        rst = r; hold = h; hz_req = hz; hz_cycles = hc; br_taken = br;
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; hold = 0; hz_req = 0; hz_cycles = 0; br_taken = 0;

        // reset for two cycles
        @(negedge clk);
        chk("rst_pc_write", pw16, 0); chk("rst_ifid_flush", fl16, 1); chk("rst_bubble", bb16, 1);
        step(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst2_pc_write", pw16, 0); chk("rst2_busy", bz16, 0);
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("post_rst_pc_write", pw16, 1); chk("post_rst_stall", sc16, 0); chk("post_rst_flush", fc16, 0);

        // single bubble
        step(0, 0, 1, 1, 0);
        @(negedge clk);
        chk("b1_pc_write", pw16, 0); chk("b1_bubble", bb16, 1);
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("b1_next_pc_write", pw16, 1); chk("b1_next_busy", bz16, 0); chk("b1_stall_cnt", sc16, 1);

        // double bubble with a taken branch held across both cycles
        do_reset();
        step(0, 0, 1, 2, 1);
        @(negedge clk);
        chk("b2c1_bubble", bb16, 1); chk("b2c1_flush", fl16, 0); chk("b2c1_busy", bz16, 0);
        step(0, 0, 1, 2, 1);
        @(negedge clk);
        chk("b2c2_bubble", bb16, 1); chk("b2c2_flush", fl16, 0); chk("b2c2_busy", bz16, 1);
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("b2_stall_cnt", sc16, 2); chk("b2_flush_cnt", fc16, 0); chk("b2_busy_end", bz16, 0);

        // branch flush
        do_reset();
        step(0, 0, 0, 0, 1);
        @(negedge clk);
        chk("br_flush", fl16, 1); chk("br_pc_write", pw16, 1);
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("br_flush_cnt", fc16, 1);

        // three bubbles with a 3-cycle hold starting in cycle 2
        do_reset();
        step(0, 0, 1, 3, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 3, 1);
            @(negedge clk);
            chk("hold_bubble", bb16, 0); chk("hold_busy", bz16, 1); chk("hold_stall_cnt", sc16, 1);
        end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("hold_last_bubble", bb16, 1);
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("hold_done_pc_write", pw16, 1); chk("hold_done_stall", sc16, 3); chk("hold_done_busy", bz16, 0);

        // reset in cycle 2 of a 3-bubble stall
        do_reset();
        step(0, 0, 1, 3, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_mid_busy", bz16, 0); chk("rst_mid_pc_write", pw16, 1); chk("rst_mid_stall", sc16, 0);

        // saturation: 20 single-cycle stalls
        do_reset();
        for (int i = 0; i < 20; i++) step(0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("sat_stall4", sc4, 15); chk("sat_stall16", sc16, 20);
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("sat_stall4_hold", sc4, 15);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) < 3), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0));
        end
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
